// File: rtl/dmem_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_pipe_ctrl
//
// Word-organised data RAM for the MEM stage. It has a valid/ready request port,
// a fixed access latency of LAT cycles and byte-lane write enables. The block
// takes one request at a time. It returns exactly one response pulse LAT cycles
// after it accepts the request, and it holds busy/!req_ready until then.
//
// Optional feature macro: DMEM_ERR_EN
//   Defined   : requests below BASE, at or above BASE+4*DEPTH, or not word
//               aligned are rejected. A rejected request does not touch the
//               array, returns rdata=0 and raises rsp_err in the response cycle.
//   Undefined : rsp_err is always 0, the word index wraps modulo DEPTH and the
//               low two address bits are ignored.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  block can accept a request (IDLE only)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_be     in   byte-lane write enables; bit i covers bits [8i+7:8i]
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  read data in the response cycle, 0 otherwise and for writes
//   rsp_err    out  access rejected; only meaningful with rsp_valid
//   busy       out  request accepted and not yet answered
// -----------------------------------------------------------------------------
module dmem_pipe_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256,
  parameter int BASE   = 1000,
  parameter int LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LAT + 1);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // With LAT=1 the request goes straight to the response cycle.
  localparam state_e FIRST_ST = (LAT == 1) ? ST_RESP : ST_WAIT;

  // Word index of a byte address: offset from BASE in words, wrapped into the array.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = (addr - BASE_A) >> 2'd2;
    return IDX_W'(word % DEPTH_A);
  endfunction

`ifdef DMEM_ERR_EN
  localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(BASE + 4 * DEPTH);

  // Address is outside the window or not word aligned.
  function automatic logic addr_reject(input logic [ADDR_W-1:0] addr);
    return (addr < BASE_A) || (addr >= LIMIT_A) || (addr[1:0] != 2'b00);
  endfunction
`endif

  // The array is not reset.
  logic [DATA_W-1:0] mem_array [DEPTH];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [NB-1:0]      be_q, be_d;
  logic               err_q, err_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               acc_err_s;
  logic               mem_wr_s;

  // Next-state, request capture and registered-output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    err_d     = err_q;
`ifdef DMEM_ERR_EN
    acc_err_s = addr_reject(req_addr);
`else
    acc_err_s = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          idx_d   = word_index(req_addr);
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = acc_err_s;
          cnt_d   = CNT_LOAD;
          state_d = FIRST_ST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    rsp_err_d   = (state_d == ST_RESP) && err_d;
    // The array cannot change between this edge and the end of RESP, so
    // sampling it here gives the same word as sampling it during RESP.
    if ((state_d == ST_RESP) && !we_d && !err_d) begin
      rsp_rdata_d = mem_array[idx_d];
    end else begin
      rsp_rdata_d = '0;
    end
  end

  // A write commits at the edge that ends the response cycle.
  assign mem_wr_s = (state_q == ST_RESP) && we_q && !err_q;

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane write into the array. Only lanes with be set are updated.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      for (int b = 0; b < NB; b++) begin
        if (be_q[b]) begin
          mem_array[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_pipe_ctrl
//
// Self-checking bench for dmem_pipe_ctrl. The main instance uses the default
// parameters (LAT=2, BASE=1000, DEPTH=256). A second instance with LAT=1
// covers back-to-back handshaking. A word-array model predicts read data,
// error flags and response latency from the address rules.
// -----------------------------------------------------------------------------
module tb_dmem_pipe_ctrl;

  localparam int LAT = 2;

`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        v1, rdy1, we1, rv1, re1, busy1;
  logic [31:0] addr1, wd1, rd1;
  logic [3:0]  be1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model_mem [256];

  dmem_pipe_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .BASE(1000), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_pipe_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .BASE(1000), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(v1), .req_ready(rdy1), .req_we(we1),
    .req_addr(addr1), .req_wdata(wd1), .req_be(be1),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word slot addressed by a byte address: word offset from 1000, wrapped over 256 words.
  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1000;
    return int'((off / 32'd4) % 32'd256);
  endfunction

  function automatic bit model_err(input logic [31:0] a);
    bit bad;
    bad = (a < 32'd1000) || (a >= 32'd2024) || ((a % 32'd4) != 32'd0);
    return ERR_EN && bad;
  endfunction

  // One complete transaction on the main instance, checked against the model.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd_o, output logic err_o);
    int          idx;
    bit          err;
    bit          got;
    logic [31:0] exp_rd;
    idx    = model_idx(addr);
    err    = model_err(addr);
    exp_rd = (we || err) ? 32'd0 : model_mem[idx];
    rd_o   = 32'd0;
    err_o  = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", req_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_rsp_valid", rsp_valid, 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk);
    #1;
    // Garbage while the block is busy must be ignored.
    req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    got = 1'b0;
    for (int c = 1; c <= LAT + 3 && !got; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        req_valid = 1'b0;
        check_eq("latency", 64'(c), 64'(LAT));
        check_eq("rsp_rdata", rsp_rdata, exp_rd);
        check_eq("rsp_err", rsp_err, err);
        check_eq("resp_busy", busy, 1);
        check_eq("resp_ready", req_ready, 0);
        rd_o  = rsp_rdata;
        err_o = rsp_err;
      end else begin
        check_eq("wait_busy", busy, 1);
        check_eq("wait_ready", req_ready, 0);
        check_eq("quiet_rdata", rsp_rdata, 0);
        check_eq("quiet_err", rsp_err, 0);
      end
    end
    req_valid = 1'b0;
    check_eq("rsp_seen", got, 1);
    if (we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  // Write 0x5 to 1012, then reset in cycle 'when' after acceptance (1 = WAIT, 2 = RESP).
  task automatic rst_mid(input int when);
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd1012; req_wdata = 32'h5; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= when; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_ready", req_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_rdata", rsp_rdata, 0);
      check_eq("rst_err", rsp_err, 0);
      @(negedge clk);
    end
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("rst_no_rsp", seen, 0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] x;
  logic [31:0] a;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'h0;
    v1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0; be1 = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", req_ready, 1);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rdata", rsp_rdata, 0);
    check_eq("reset_err", rsp_err, 0);
    check_eq("reset_ready_l1", rdy1, 1);
    check_eq("reset_rsp_valid_l1", rv1, 0);
    rst = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < 256; i++) do_req(1'b1, 32'd1000 + 32'(4 * i), $urandom, 4'hF, rd, er);

    do_req(1'b1, 32'd1004, 32'hDEADBEEF, 4'hF, rd, er);
    do_req(1'b0, 32'd1004, 32'h0, 4'h0, rd, er);
    check_eq("dir_rd_1004", rd, 32'hDEADBEEF);

    do_req(1'b1, 32'd1008, 32'h11223344, 4'hF, rd, er);
    do_req(1'b1, 32'd1008, 32'hAABBCCDD, 4'b0101, rd, er);
    do_req(1'b0, 32'd1008, 32'h0, 4'hF, rd, er);
    check_eq("dir_be_merge", rd, 32'h11BB33DD);

    do_req(1'b1, 32'd1012, 32'h0BADF00D, 4'hF, rd, er);
    rst_mid(1);
    do_req(1'b0, 32'd1012, 32'h0, 4'h0, rd, er);
    check_eq("dir_rst_wait_keep", rd, 32'h0BADF00D);
    rst_mid(2);
    do_req(1'b0, 32'd1012, 32'h0, 4'h0, rd, er);
    check_eq("dir_rst_resp_keep", rd, 32'h0BADF00D);

    x = $urandom;
    do_req(1'b1, 32'd1016, 32'h12345678, 4'hF, rd, er);
    do_req(1'b1, 32'd1016, x, 4'h0, rd, er);
    do_req(1'b0, 32'd1016, 32'h0, 4'h0, rd, er);
    check_eq("dir_be_zero", rd, 32'h12345678);

`ifdef DMEM_ERR_EN
    do_req(1'b0, 32'd996, 32'h0, 4'h0, rd, er);
    check_eq("dir_err_996", er, 1);
    check_eq("dir_err_996_rd", rd, 0);
    do_req(1'b1, 32'd1000, 32'hCAFE0001, 4'hF, rd, er);
    do_req(1'b1, 32'd1002, 32'hFF, 4'hF, rd, er);
    check_eq("dir_err_1002", er, 1);
    do_req(1'b0, 32'd1000, 32'h0, 4'h0, rd, er);
    check_eq("dir_keep_1000", rd, 32'hCAFE0001);
    check_eq("dir_ok_1000", er, 0);
    do_req(1'b0, 32'd2024, 32'h0, 4'h0, rd, er);
    check_eq("dir_err_2024", er, 1);
`else
    do_req(1'b1, 32'd2024, 32'h7, 4'hF, rd, er);
    do_req(1'b0, 32'd1000, 32'h0, 4'h0, rd, er);
    check_eq("dir_wrap_rd", rd, 32'h7);
    check_eq("dir_wrap_err", er, 0);
`endif

    // Random mix of reads and writes, including misaligned and out-of-window addresses.
    for (int i = 0; i < 300; i++) begin
      a = 32'd990 + 32'($urandom_range(0, 1050));
      do_req(1'($urandom), a, $urandom, 4'($urandom), rd, er);
    end

    // LAT=1 instance: request held high, writes then reads of word 0.
    @(negedge clk);
    x = $urandom;
    v1 = 1'b1; we1 = 1'b1; addr1 = 32'd1000; wd1 = x; be1 = 4'hF;
    for (int k = 0; k < 16; k++) begin
      if (k >= 10) we1 = 1'b0;
      check_eq("l1_ready", rdy1, (k % 2 == 0) ? 1 : 0);
      check_eq("l1_busy", busy1, (k % 2 == 1) ? 1 : 0);
      check_eq("l1_rsp_valid", rv1, (k % 2 == 1) ? 1 : 0);
      check_eq("l1_rdata", rd1, ((k % 2 == 1) && (k >= 11)) ? 64'(x) : 64'd0);
      check_eq("l1_err", re1, 0);
      @(negedge clk);
    end
    v1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
